dbus_arbiter: RTL and testbench

//  Shares the single CPU data-bus port of the system bridge (DM 0x0000-0x2fff, Timer0 0x7f00,

---
 rtl/dbus_arbiter.sv | 118 +++++++++++
 tb/tb_dbus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the bridge data port: the CPU M-stage has priority, and the DMA engine
// is protected by a starvation counter and may hold the bus for bounded locked bursts.
module dbus_arbiter #(
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CW        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [3:0]  dma_byteen,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  bus_owner
);

    localparam logic [CW-1:0] MAX_WAIT_C  = CW'(MAX_WAIT);
    localparam logic [CW-1:0] BURST_MAX_C = CW'(BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_DMA,
        ST_DMA_LOCK
    } state_t;

    state_t        st;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] beat_cnt;
    logic          lock_cont;
    logic          cpu_gnt;
    logic          dma_gnt_w;

    // Combinational grant; a burst that reached BURST_MAX loses its continuation right.
    always_comb begin
        lock_cont = (st == ST_DMA_LOCK) && dma_req && dma_lock && (beat_cnt < BURST_MAX_C);
        cpu_gnt   = 1'b0;
        dma_gnt_w = 1'b0;
        if (reset) begin
            cpu_gnt   = 1'b0;
            dma_gnt_w = 1'b0;
        end else if (lock_cont) begin
            dma_gnt_w = 1'b1;
        end else if (dma_req && (wait_cnt == MAX_WAIT_C)) begin
            dma_gnt_w = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt_w = 1'b1;
        end
    end

    // Bus mux and per-master return paths.
    always_comb begin
        bus_addr   = 32'd0;
        bus_byteen = 4'd0;
        bus_wdata  = 32'd0;
        cpu_rdata  = 32'd0;
        dma_rdata  = 32'd0;
        if (cpu_gnt) begin
            bus_addr   = cpu_addr;
            bus_byteen = cpu_byteen;
            bus_wdata  = cpu_wdata;
            cpu_rdata  = bus_rdata;
        end else if (dma_gnt_w) begin
            bus_addr   = dma_addr;
            bus_byteen = dma_byteen;
            bus_wdata  = dma_wdata;
            dma_rdata  = bus_rdata;
        end
        dma_gnt   = dma_gnt_w;
        cpu_stall = cpu_req && !cpu_gnt && !reset;
        bus_owner = {dma_gnt_w, cpu_gnt};
    end

    // Owner history and counters; a locked grant that is not a continuation opens a new burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ST_IDLE;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (dma_gnt_w) begin
                st <= dma_lock ? ST_DMA_LOCK : ST_DMA;
            end else if (cpu_gnt) begin
                st <= ST_CPU;
            end else begin
                st <= ST_IDLE;
            end

            if (dma_gnt_w && dma_lock) begin
                beat_cnt <= lock_cont ? beat_cnt + CW'(1) : CW'(1);
            end else begin
                beat_cnt <= '0;
            end

            if (dma_req && !dma_gnt_w) begin
                wait_cnt <= (wait_cnt == MAX_WAIT_C) ? wait_cnt : wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: each step queues its expected bus view, then pops and checks it.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_lock;
    logic [31:0] dma_addr;
    logic [3:0]  dma_byteen;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_owner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [1:0]  owner;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] crd;
        logic [31:0] drd;
        logic        stall;
        logic        gnt;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] O_NONE = 2'b00;
    localparam logic [1:0] O_CPU  = 2'b01;
    localparam logic [1:0] O_DMA  = 2'b10;

    dbus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_lock   (dma_lock),
        .dma_addr   (dma_addr),
        .dma_byteen (dma_byteen),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_owner  (bus_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Expected bus view follows from the expected owner and the currently driven inputs.
    task automatic step(input logic [1:0] owner, input string tag);
        exp_t e;
        exp_t g;
        e.tag   = tag;
        e.owner = owner;
        e.addr  = (owner == O_CPU) ? cpu_addr   : (owner == O_DMA) ? dma_addr   : 32'd0;
        e.be    = (owner == O_CPU) ? cpu_byteen : (owner == O_DMA) ? dma_byteen : 4'd0;
        e.wdata = (owner == O_CPU) ? cpu_wdata  : (owner == O_DMA) ? dma_wdata  : 32'd0;
        e.crd   = (owner == O_CPU) ? bus_rdata : 32'd0;
        e.drd   = (owner == O_DMA) ? bus_rdata : 32'd0;
        e.stall = cpu_req && (owner != O_CPU) && !reset;
        e.gnt   = (owner == O_DMA);
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            g = sb.pop_front();
            chk(g.tag, "owner",     32'(bus_owner),  32'(g.owner));
            chk(g.tag, "bus_addr",  bus_addr,        g.addr);
            chk(g.tag, "bus_byteen",32'(bus_byteen), 32'(g.be));
            chk(g.tag, "bus_wdata", bus_wdata,       g.wdata);
            chk(g.tag, "cpu_rdata", cpu_rdata,       g.crd);
            chk(g.tag, "dma_rdata", dma_rdata,       g.drd);
            chk(g.tag, "cpu_stall", 32'(cpu_stall),  32'(g.stall));
            chk(g.tag, "dma_gnt",   32'(dma_gnt),    32'(g.gnt));
        end
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        cpu_req    = 1'b1;
        cpu_addr   = 32'h0000_0040;
        cpu_byteen = 4'h3;
        cpu_wdata  = 32'h1111_2222;
        dma_req    = 1'b1;
        dma_lock   = 1'b1;
        dma_addr   = 32'h0000_1000;
        dma_byteen = 4'hF;
        dma_wdata  = 32'h3333_4444;
        bus_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        step(O_NONE, "reset");
        step(O_NONE, "reset2");
        reset = 1'b0;

        // T1: lone CPU read
        dma_req    = 1'b0;
        dma_lock   = 1'b0;
        cpu_addr   = 32'h0000_0010;
        cpu_byteen = 4'h0;
        cpu_wdata  = 32'h0;
        bus_rdata  = 32'h1234_5678;
        step(O_CPU, "t1_cpu_rd");

        // T6: idle bus
        cpu_req   = 1'b0;
        bus_rdata = 32'hDEAD_BEEF;
        step(O_NONE, "t6_idle");

        // T2: DMA starves for MAX_WAIT cycles, then is force-granted
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_0020;
        dma_req   = 1'b1;
        dma_addr  = 32'h0000_1000;
        dma_byteen = 4'h0;
        dma_wdata = 32'h0;
        bus_rdata = 32'h0BAD_0001;
        for (int i = 0; i < 8; i++) step(O_CPU, "t2_cpu_first");
        step(O_DMA, "t2_dma_forced");
        step(O_CPU, "t2_cpu_resume");
        dma_req = 1'b0;
        step(O_CPU, "t2_cpu_alone");

        // T4: DMA write reaches the bus only in its forced slot, CPU write held off
        cpu_addr   = 32'h0000_0100;
        cpu_byteen = 4'h3;
        cpu_wdata  = 32'h5555_5555;
        dma_req    = 1'b1;
        dma_addr   = 32'h0000_7F04;
        dma_byteen = 4'hF;
        dma_wdata  = 32'h0000_00AA;
        for (int i = 0; i < 8; i++) step(O_CPU, "t4_cpu_wr");
        step(O_DMA, "t4_dma_wr");
        dma_req = 1'b0;
        step(O_CPU, "t4_cpu_wr_after");
        cpu_req = 1'b0;
        step(O_NONE, "t4_idle");

        // T3: locked burst, forced release to CPU, then a fresh burst
        dma_req    = 1'b1;
        dma_lock   = 1'b1;
        dma_addr   = 32'h0000_2000;
        dma_byteen = 4'h0;
        dma_wdata  = 32'h0;
        step(O_DMA, "t3_beat1");
        cpu_req    = 1'b1;
        cpu_addr   = 32'h0000_7F00;
        cpu_byteen = 4'h0;
        step(O_DMA, "t3_beat2");
        step(O_DMA, "t3_beat3");
        step(O_DMA, "t3_beat4");
        step(O_CPU, "t3_release_cpu");
        cpu_req = 1'b0;
        step(O_DMA, "t3_new_beat1");
        cpu_req = 1'b1;
        step(O_DMA, "t3_new_beat2");
        step(O_DMA, "t3_new_beat3");
        step(O_DMA, "t3_new_beat4");
        step(O_CPU, "t3_new_release");
        dma_lock = 1'b0;
        dma_req  = 1'b0;
        step(O_CPU, "t3_cpu_alone");

        // Lock dropped mid-burst releases at once to the CPU
        cpu_req  = 1'b0;
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        step(O_DMA, "drop_beat1");
        cpu_req  = 1'b1;
        dma_lock = 1'b0;
        step(O_CPU, "drop_cpu");
        dma_req = 1'b0;
        cpu_req = 1'b0;
        step(O_NONE, "drop_idle");

        // T5: reset lands on beat 2 of a locked write burst
        dma_req    = 1'b1;
        dma_lock   = 1'b1;
        dma_addr   = 32'h0000_0200;
        dma_byteen = 4'hF;
        dma_wdata  = 32'hA5A5_A5A5;
        step(O_DMA, "t5_beat1");
        reset = 1'b1;
        step(O_NONE, "t5_reset_mid");
        reset = 1'b0;
        step(O_DMA, "t5_restart_beat1");
        cpu_req = 1'b1;
        step(O_DMA, "t5_restart_beat2");
        step(O_DMA, "t5_restart_beat3");
        step(O_DMA, "t5_restart_beat4");
        step(O_CPU, "t5_release");
        dma_req = 1'b0;
        cpu_req = 1'b0;
        bus_rdata = 32'hDEAD_BEEF;
        step(O_NONE, "t6_final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
